// File: rtl/pmem_line_responder_pkg.sv
// Shared LC-3b memory-side types: line/word typedefs and the pmem responder state encoding.
package lc3b_types;

  typedef logic [127:0] lc3b_block;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

endpackage

// File: rtl/pmem_line_responder_array.sv
// Line storage for the pmem responder: combinational read, synchronous write enable.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  logic [LINE_WIDTH-1:0] mem_q [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency line memory answering the pmem_read/pmem_write/pmem_resp protocol.
// Optional checker: define PMEM_LINE_RESPONDER_PROTOCOL_CHECK_EN to drive protocol_err.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 16,
  parameter int OFFSET_BITS   = 4,
  parameter int INDEX_BITS    = 6,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  protocol_err
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] R_M1 = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] W_M1 = CNT_W'(WRITE_LATENCY - 1);

  pmem_state_e           state_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d, lat_m1;
  logic [INDEX_BITS-1:0] idx_q, arr_idx;
  logic                  wr_op_q;
  logic [LINE_WIDTH-1:0] wdata_q, arr_rdata, rdata_q;
  logic                  resp_q, req, arr_we;
  logic                  addr_unused;

  assign req         = pmem_read | pmem_write;
  assign lat_m1      = pmem_write ? W_M1 : R_M1;
  assign cnt_d       = cnt_q - CNT_W'(1);
  assign addr_unused = ^{pmem_address[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                         pmem_address[OFFSET_BITS-1:0]};

  // In IDLE the array is addressed by the live request so a 1-cycle latency can read on acceptance.
  assign arr_idx = (state_q == IDLE) ? pmem_address[OFFSET_BITS +: INDEX_BITS] : idx_q;
  // Gating with rst_n keeps a reset during RESP from committing the write.
  assign arr_we  = (state_q == RESP) && wr_op_q && rst_n;

  pmem_line_array #(
    .LINE_WIDTH(LINE_WIDTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .idx_i  (arr_idx),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q <= lat_m1;
            if (lat_m1 != '0) begin
              state_q <= BUSY;
            end else begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!pmem_write) rdata_q <= arr_rdata;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!wr_op_q) rdata_q <= arr_rdata;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      idx_q   <= pmem_address[OFFSET_BITS +: INDEX_BITS];
      wr_op_q <= pmem_write;
      wdata_q <= pmem_wdata;
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rdata_q;

`ifdef PMEM_LINE_RESPONDER_PROTOCOL_CHECK_EN
  logic                  err_q, rd_q, both_hi, busy_viol;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      addr_q <= pmem_address;
      rd_q   <= pmem_read;
    end
  end

  assign both_hi   = pmem_read & pmem_write;
  assign busy_viol = (state_q == BUSY) &&
                     ((pmem_read != rd_q) || (pmem_write != wr_op_q) ||
                      (pmem_address != addr_q) || (wr_op_q && (pmem_wdata != wdata_q)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (both_hi || busy_viol) begin
      err_q <= 1'b1;
      $error("pmem protocol violation: both=%0b busy_change=%0b", both_hi, busy_viol);
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: default-latency instance A and READ_LATENCY=1 instance B.
module tb_pmem_line_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [15:0]     a_addr, b_addr;
  logic            a_rd, a_wr, b_rd, b_wr;
  lc3b_block       a_wdata, b_wdata, a_rdata, b_rdata;
  logic            a_resp, b_resp, a_err, b_err;

  pmem_line_responder u_dut_a (
    .clk(clk), .rst_n(rst_n), .pmem_address(a_addr), .pmem_read(a_rd),
    .pmem_write(a_wr), .pmem_wdata(a_wdata), .pmem_rdata(a_rdata),
    .pmem_resp(a_resp), .protocol_err(a_err)
  );

  pmem_line_responder #(.READ_LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pmem_address(b_addr), .pmem_read(b_rd),
    .pmem_write(b_wr), .pmem_wdata(b_wdata), .pmem_rdata(b_rdata),
    .pmem_resp(b_resp), .protocol_err(b_err)
  );

  typedef struct {
    int        cyc;
    bit        rd;
    lc3b_block data;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic exp_err;

  localparam lc3b_block D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam lc3b_block DAA = {16{8'hAA}};
  localparam lc3b_block D55 = {16{8'h55}};
  localparam lc3b_block D11 = {16{8'h11}};
  localparam lc3b_block D2  = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
  localparam lc3b_block D3  = 128'hC0FFEE00_DEADBEEF_12345678_9ABCDEF0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input lc3b_block act, input lc3b_block exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_resp) begin
        if (qa.size() == 0) begin
          check("a_unexpected_resp", 1, 0);
        end else begin
          ea = qa.pop_front();
          check("a_resp_cycle", cyc, ea.cyc);
          check("a_rdata_resp", a_rdata, ea.rd ? ea.data : '0);
        end
      end else begin
        check("a_rdata_idle", a_rdata, '0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_resp) begin
        if (qb.size() == 0) begin
          check("b_unexpected_resp", 1, 0);
        end else begin
          eb = qb.pop_front();
          check("b_resp_cycle", cyc, eb.cyc);
          check("b_rdata_resp", b_rdata, eb.rd ? eb.data : '0);
        end
      end else begin
        check("b_rdata_idle", b_rdata, '0);
      end
    end
  end

  // Called just after a posedge; holds the request until pmem_resp, then releases it
  // so the next call lands in the IDLE cycle right after RESP.
  task automatic req(input int sel, input logic [15:0] addr, input logic rd, input logic wr,
                     input lc3b_block wdata, input lc3b_block expdata, input int lat);
    exp_t e;
    bit   got;
    e.cyc  = cyc + lat;
    e.rd   = rd && !wr;
    e.data = expdata;
    if (sel == 0) begin
      a_addr = addr; a_rd = rd; a_wr = wr; a_wdata = wdata;
      qa.push_back(e);
    end else begin
      b_addr = addr; b_rd = rd; b_wr = wr; b_wdata = wdata;
      qb.push_back(e);
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (sel == 0) ? a_resp : b_resp;
    end
    if (!got) check("resp_timeout", 0, 1);
    if (sel == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
    else          begin b_rd = 1'b0; b_wr = 1'b0; end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef PMEM_LINE_RESPONDER_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0;
    a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wdata = '0;
    b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_resp",  a_resp,  0);
    check("rst_a_rdata", a_rdata, '0);
    check("rst_a_err",   a_err,   0);
    check("rst_b_resp",  b_resp,  0);
    check("rst_b_rdata", b_rdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1-2: write then read back the same line
    req(0, 16'h0040, 1'b0, 1'b1, D1, '0, 4);
    req(0, 16'h0040, 1'b1, 1'b0, '0, D1, 4);

    // 3: aliasing on upper address bits
    req(0, 16'h0010, 1'b0, 1'b1, DAA, '0, 4);
    req(0, 16'h0410, 1'b1, 1'b0, '0, DAA, 4);
    req(0, 16'h0040, 1'b1, 1'b0, '0, D1, 4);

    // 4: READ_LATENCY=1 instance, back-to-back reads
    req(1, 16'h0050, 1'b0, 1'b1, D2, '0, 4);
    req(1, 16'h0050, 1'b1, 1'b0, '0, D2, 1);
    req(1, 16'h0450, 1'b1, 1'b0, '0, D2, 1);
    req(1, 16'h0050, 1'b1, 1'b0, '0, D2, 1);

    // 5: reset in the middle of a write aborts it
    req(0, 16'h0020, 1'b0, 1'b1, D11, '0, 4);
    a_addr = 16'h0020; a_wr = 1'b1; a_wdata = D55;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; a_wr = 1'b0;
    @(posedge clk); #1;
    check("abort_resp_in_reset", a_resp, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req(0, 16'h0020, 1'b1, 1'b0, '0, D11, 4);

    // 6: simultaneous read and write is serviced as a write
    check("err_before_both", a_err, 0);
    req(0, 16'h0030, 1'b1, 1'b1, D3, '0, 4);
    check("err_after_both", a_err, exp_err);
    req(0, 16'h0030, 1'b1, 1'b0, '0, D3, 4);
    check("err_sticky", a_err, exp_err);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("err_cleared", a_err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Physical-memory responder for the pmem_read/pmem_write/pmem_resp line protocol driven by the cache and victim-buffer controllers.
- Accepts one 128-bit line read or write at a time.
- Models a fixed, parameterised access latency and backs the data with an internal line array.
- Sits below the victim buffer; the sole target of pmem traffic in simulation and in the synthesised memory model.

Parameters:
- LINE_WIDTH, 128, bits per line.
- ADDR_WIDTH, 16, byte-address width of pmem_address.
- OFFSET_BITS, 4, byte-offset bits within a line; ignored for indexing.
- INDEX_BITS, 6, line-index bits; array holds 2**INDEX_BITS lines.
- READ_LATENCY, 4, cycles from request acceptance to pmem_resp for reads; must be >= 1.
- WRITE_LATENCY, 4, the same measure for writes; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- pmem_address  in  ADDR_WIDTH  byte address of the line.
- pmem_read  in  1  read request; initiator holds it high until pmem_resp.
- pmem_write  in  1  write request; initiator holds it high until pmem_resp.
- pmem_wdata  in  LINE_WIDTH  write data; stable while pmem_write is high.
- pmem_rdata  out  LINE_WIDTH  read data; valid only in the cycle pmem_resp is high for a read.
- pmem_resp  out  1  one-cycle completion pulse.
- protocol_err  out  1  sticky protocol-violation flag; see Optional Feature.

Behaviour:
- Reset (rst_n low at posedge):
  - state goes to IDLE; latency counter clears to 0.
  - pmem_resp = 0, pmem_rdata = 0, protocol_err = 0.
  - Array contents are not reset.
- Indexing:
  - Line index = pmem_address[OFFSET_BITS +: INDEX_BITS].
  - Upper address bits are ignored, so addresses alias modulo the array size.
- States:
  - IDLE: if pmem_write or pmem_read is sampled high, latch the address, the op (write has priority when both are high), and pmem_wdata. Load the counter with the selected latency minus 1. Go to BUSY if that value is greater than 0, otherwise go directly to RESP.
  - BUSY: decrement the counter each cycle; go to RESP on the cycle the counter reaches 0. Request inputs are ignored (the latched copies are used).
  - RESP: pmem_resp = 1 for exactly this cycle. For a read, pmem_rdata = array[latched index]. For a write, array[latched index] is written at the end of this cycle. Go unconditionally to IDLE.
- Latency: request first sampled in IDLE at cycle T gives pmem_resp high in cycle T+LATENCY.
- Throughput: a new request is accepted no earlier than the cycle after RESP, because the initiator drops its request after seeing pmem_resp. Back-to-back request spacing is LATENCY+1.
- pmem_rdata outside a read RESP cycle: holds 0.
- Read-after-write to the same line returns the new data, because the write commits at the end of RESP.
- Request dropped during BUSY: the transaction still completes and pmem_resp still pulses; the write still commits.
- Reset during BUSY or RESP: the transaction is aborted and a pending write is not committed.
- Simultaneous read and write:
  - serviced as a write;
  - sets protocol_err when the feature is enabled.

Optional Feature:
- Macro: PMEM_LINE_RESPONDER_PROTOCOL_CHECK_EN.
- Defined: protocol_err is set (sticky until reset) by any of:
  - pmem_read and pmem_write both high in the same cycle;
  - the request or pmem_address changing while in BUSY;
  - pmem_wdata changing during a write in BUSY.
  Simulation also emits a $error per violation.
- Undefined: protocol_err is tied to 0 and no checking logic is present.

Decomposition:
- Shared package lc3b_types holds:
  - the lc3b_block typedef (128-bit line);
  - the lc3b_word typedef;
  - the pmem state enum (IDLE, BUSY, RESP).
- Sub-module pmem_line_array: 2**INDEX_BITS x LINE_WIDTH storage with combinational read and synchronous write enable.

Test Plan:
1. Reset, then write 0x0123...CDEF to address 0x0040 with WRITE_LATENCY=4 -> pmem_resp pulses exactly at T+4 for one cycle; state returns to IDLE.
2. Read 0x0040 after test 1 -> pmem_rdata = 0x0123...CDEF in the resp cycle only, 0 before and after.
3. Write 0xAA..AA to 0x0010, then read 0x0410 (aliases to index 1) -> read returns 0xAA..AA.
4. Set READ_LATENCY=1 -> pmem_resp appears the cycle after the request is first seen; back-to-back reads are spaced 2 cycles apart.
5. Drop rst_n during BUSY of a write of 0x55..55 to 0x0020, then read 0x0020 -> no pmem_resp for the aborted write; the read returns the prior contents.
6. With the macro defined, assert pmem_read and pmem_write together on 0x0030 -> the write is performed and protocol_err goes high and stays high until reset; without the macro, protocol_err stays 0.
